// File: rtl/alu_op_sequencer_pkg.sv
// Shared state encoding, default operand width and LED phase codes for the ALU front-end.
// Pure declarations: no latency, no flow control.
package alu_op_sequencer_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [2:0] PHASE_A    = 3'b001;
  localparam logic [2:0] PHASE_B    = 3'b010;
  localparam logic [2:0] PHASE_OP   = 3'b100;
  localparam logic [2:0] PHASE_NONE = 3'b000;

endpackage

// File: rtl/alu_op_sequencer_button_debounce.sv
// Pushbutton synchronizer + debouncer producing a one-cycle press pulse on an accepted rising edge.
// Latency DEBOUNCE_CYCLES+2 cycles from raw edge to pulse; no backpressure, pulses are not queued.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Walks the user through A, B and op entry, drives the add/sub datapath and latches its result for display.
// Result latched one cycle after the op press is seen; no backpressure, presses outside valid phases are dropped.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int W               = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_next,
  input  logic [W-1:0] sw,
  input  logic         sel_sw,
  input  logic [W:0]   alu_res,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_sel,
  output logic [W:0]   disp_value,
  output logic [2:0]   phase,
  output logic         done
);

  logic press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .press (press)
  );

  state_e         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           op_sel_q, op_sel_d;
  logic [W:0]     result_q, result_d;
  logic [W:0]     disp_q, disp_d;
  logic           done_q, done_d;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sel_d = op_sel_q;
    result_d = result_q;
    disp_d   = disp_q;
    done_d   = 1'b0;
    case (state_q)
      S_A: begin
        disp_d = {1'b0, sw};
        if (press) begin
          op_a_d  = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        disp_d = {1'b0, sw};
        if (press) begin
          op_b_d  = sw;
          state_d = S_OP;
        end
      end
      S_OP: begin
        disp_d = {{W{1'b0}}, sel_sw};
        if (press) begin
          op_sel_d = sel_sw;
          state_d  = S_EXEC;
        end
      end
      // Operands have been stable for a full cycle, so alu_res has settled.
      S_EXEC: begin
        result_d = alu_res;
        done_d   = 1'b1;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        disp_d = result_q;
        if (press) begin
          op_a_d   = '0;
          op_b_d   = '0;
          op_sel_d = 1'b0;
          state_d  = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= 1'b0;
      result_q <= '0;
      disp_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      result_q <= result_d;
      disp_q   <= disp_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    phase = PHASE_NONE;
    case (state_q)
      S_A:     phase = PHASE_A;
      S_B:     phase = PHASE_B;
      S_OP:    phase = PHASE_OP;
      default: phase = PHASE_NONE;
    endcase
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_sel     = op_sel_q;
  assign disp_value = disp_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a short debounce window and a behavioural 9-bit add/sub load.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_next;
  logic [W-1:0] sw;
  logic         sel_sw;
  logic [W:0]   alu_res;
  logic [W-1:0] op_a, op_b;
  logic         op_sel;
  logic [W:0]   disp_value;
  logic [2:0]   phase;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit hit_exec;

  always #5 clk = ~clk;

  // Stand-in for the 9-bit adder/subtractor: operands zero-extended, result wraps in W+1 bits.
  assign alu_res = op_sel ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .sw         (sw),
    .sel_sw     (sel_sw),
    .alu_res    (alu_res),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sel     (op_sel),
    .disp_value (disp_value),
    .phase      (phase),
    .done       (done)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_press();
    btn_next = 1'b1;
    cyc(8);
    btn_next = 1'b0;
    cyc(8);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; btn_next = 1'b0; sw = 8'h33; sel_sw = 1'b0;
    cyc(3);
    rst = 1'b0;
    check("rst_phase",  phase, 3'b001);
    check("rst_disp",   disp_value, 9'h000);
    check("rst_done",   done, 1'b0);
    check("rst_op_a",   op_a, 8'h00);
    check("rst_op_b",   op_b, 8'h00);
    check("rst_op_sel", op_sel, 1'b0);
    cyc(1);
    check("a_live_disp", disp_value, 9'h033);

    // Add 25 + 10
    sw = 8'd25; do_press();
    check("add_op_a", op_a, 8'd25);
    check("add_phase_b", phase, 3'b010);
    sw = 8'd10; do_press();
    check("add_op_b", op_b, 8'd10);
    check("add_phase_op", phase, 3'b100);
    sel_sw = 1'b0; do_press();
    check("add_done_cnt", done_cnt, 1);
    check("add_phase_show", phase, 3'b000);
    check("add_disp", disp_value, 9'h023);
    check("add_op_sel", op_sel, 1'b0);
    do_press();
    check("add_back_phase", phase, 3'b001);
    check("add_clr_a", op_a, 8'h00);
    check("add_clr_b", op_b, 8'h00);

    // Subtract 10 - 25 = -15
    sw = 8'd10; do_press();
    sw = 8'd25; do_press();
    sel_sw = 1'b1; do_press();
    check("sub_disp", disp_value, 9'h1F1);
    check("sub_phase", phase, 3'b000);
    check("sub_op_sel", op_sel, 1'b1);
    check("sub_done_cnt", done_cnt, 2);
    sel_sw = 1'b0;
    do_press();
    check("sub_back_phase", phase, 3'b001);
    check("sub_clr_a", op_a, 8'h00);
    check("sub_clr_b", op_b, 8'h00);
    check("sub_clr_sel", op_sel, 1'b0);

    // Held button latches A once; later switch change leaves A alone
    sw = 8'h55; btn_next = 1'b1; cyc(100); btn_next = 1'b0; cyc(10);
    check("held_phase", phase, 3'b010);
    check("held_op_a", op_a, 8'h55);
    sw = 8'hAA; cyc(5);
    check("iso_op_a_hold", op_a, 8'h55);
    check("iso_disp_live", disp_value, 9'h0AA);
    do_press();
    check("iso_op_a", op_a, 8'h55);
    check("iso_op_b", op_b, 8'hAA);
    check("iso_phase_op", phase, 3'b100);
    do_press();
    check("iso_disp", disp_value, 9'h0FF);
    check("iso_done_cnt", done_cnt, 3);
    do_press();
    check("iso_back_phase", phase, 3'b001);

    // Bounce: two 3-cycle highs separated by a 2-cycle low must be rejected
    btn_next = 1'b1; cyc(3);
    btn_next = 1'b0; cyc(2);
    btn_next = 1'b1; cyc(3);
    btn_next = 1'b0; cyc(10);
    check("bounce_phase", phase, 3'b001);
    btn_next = 1'b1; cyc(6);
    btn_next = 1'b0; cyc(10);
    check("steady_phase", phase, 3'b010);

    // Reset while in S_EXEC
    do_press();
    check("pre_exec_phase", phase, 3'b100);
    btn_next = 1'b1;
    hit_exec = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (phase == 3'b000) begin
        hit_exec = 1'b1;
        break;
      end
    end
    check("exec_reached", hit_exec, 1'b1);
    rst = 1'b1;
    cyc(1);
    check("exec_rst_phase", phase, 3'b001);
    check("exec_rst_disp", disp_value, 9'h000);
    check("exec_rst_result", dut.result_q, 9'h000);
    check("exec_rst_done", done, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check("exec_no_done", done_cnt, 3);
    check("held_thru_rst_phase", phase, 3'b010);
    btn_next = 1'b0;
    cyc(10);
    check("held_thru_rst_single", phase, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
